// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller sequencing one full-adder cell over WIDTH cycles
//
// Optional feature macro: SERIAL_ADD_OVF_EN (adds the ovf output)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands a/b valid
//   in_ready   controller can accept operands (IDLE only)
//   a, b       WIDTH-bit addends
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   sum        A+B modulo 2^WIDTH
//   carry      carry out of bit WIDTH-1
//   busy       high in RUN or DONE
//   ovf        two's-complement overflow (SERIAL_ADD_OVF_EN only)

`timescale 1ns/1ps

module serial_add_ha (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             busy
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             c_q;
   logic [CNT_W-1:0] cnt;

   // Full adder as two half adders: first cell adds the operand bits,
   // second adds the running carry; either cell's carry propagates.
   logic p;
   logic g;
   logic s_bit;
   logic g2;
   logic c_next;

   serial_add_ha u_ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(p),     .c(g));
   serial_add_ha u_ha1 (.x(p),       .y(c_q),     .s(s_bit), .c(g2));

   assign c_next = g | g2;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         c_q   <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         carry <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  c_q   <= 1'b0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               // LSB-first: each new bit enters at the MSB so that after
               // WIDTH shifts bit 0 of the result sits at sum[0].
               sum  <= {s_bit, sum[WIDTH-1:1]};
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               c_q  <= c_next;
               if (cnt == LAST) begin
                  // Counter holds at WIDTH-1 rather than wrapping.
                  state <= DONE;
                  carry <= c_next;
`ifdef SERIAL_ADD_OVF_EN
                  // c_q is the carry into the MSB on this final step.
                  ovf   <= c_q ^ c_next;
`endif
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
